// File: rtl/stack_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stack_cmd_sequencer_pkg
// Shared definitions for the stack command front-end:
//   - DW       : data width of the LIFO stack macro
//   - OP_PUSH / OP_POP : command opcode encodings (00/11 are illegal)
//   - state_e  : sequencer state enumeration
// -----------------------------------------------------------------------------
package stack_cmd_sequencer_pkg;

    localparam int DW = 8;

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        EXEC0 = 3'd2,
        EXEC1 = 3'd3,
        CAPT  = 3'd4,
        ERR   = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/stack_cmd_sequencer_depth.sv
// -----------------------------------------------------------------------------
// stack_depth_tracker
// Saturating up/down counter of stack occupancy with registered flags.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   inc_i, dec_i  : one-cycle requests to add / remove one entry
//   depth_o       : current entry count (0..DEPTH)
//   full_o        : depth_o == DEPTH
//   empty_o       : depth_o == 0
// -----------------------------------------------------------------------------
module stack_depth_tracker #(
    parameter int DEPTH = 256,
    parameter int CW    = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] depth_q;
    logic [CW-1:0] depth_d;
    logic          full_q;
    logic          empty_q;

    // Next depth: the guards keep the count inside 0..DEPTH even if a
    // request arrives at a boundary.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && (depth_q != DEPTH_C)) begin
            depth_d = depth_q + ONE_C;
        end else if (dec_i && !inc_i && (depth_q != ZERO_C)) begin
            depth_d = depth_q - ONE_C;
        end else begin
            depth_d = depth_q;
        end
    end

    // Counter and flags registered together so the flags always match depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= ZERO_C;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            depth_q <= depth_d;
            full_q  <= (depth_d == DEPTH_C);
            empty_q <= (depth_d == ZERO_C);
        end
    end

    assign depth_o = depth_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/stack_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// stack_cmd_sequencer
// Accepts push/pop commands on a valid/ready interface and converts each into
// the stack macro's two-cycle phase-aligned strobe pair (phase 0 then
// phase 1). Refuses overflow, underflow and illegal opcodes, and returns one
// response pulse per command.
// Ports:
//   clk, rst              : clock (shared with stack), sync active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op, cmd_data      : opcode (01 push, 10 pop) and push byte
//   stack_push/stack_pop  : strobes to the stack macro
//   stack_din/stack_dout  : stack write data / stack output byte
//   rsp_valid/rsp_data/rsp_err : one-cycle response, data and refusal flag
//   depth, full, empty    : occupancy status
// -----------------------------------------------------------------------------
module stack_cmd_sequencer
    import stack_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          stack_push,
    output logic          stack_pop,
    output logic [DW-1:0] stack_din,
    input  logic [DW-1:0] stack_dout,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [CW-1:0] depth,
    output logic          full,
    output logic          empty
);

    state_e        state_q;
    logic          phase_q;
    logic [1:0]    op_q;
    logic [DW-1:0] data_q;
    logic          push_q;
    logic          pop_q;
    logic [DW-1:0] din_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;

    logic          is_push_s;
    logic          is_pop_s;
    logic          refuse_s;
    logic          inc_s;
    logic          dec_s;
    logic          full_s;
    logic          empty_s;

    // Decode the offered command and decide whether it must be refused.
    always_comb begin
        is_push_s = (cmd_op == OP_PUSH);
        is_pop_s  = (cmd_op == OP_POP);
        refuse_s  = (!is_push_s && !is_pop_s)
                  || (is_push_s && full_s)
                  || (is_pop_s && empty_s);
    end

    // Depth moves on the edge that ends EXEC1, i.e. once the macro has
    // completed both halves of the operation.
    assign inc_s = (state_q == EXEC1) && push_q;
    assign dec_s = (state_q == EXEC1) && pop_q;

    stack_depth_tracker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_depth (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (inc_s),
        .dec_i   (dec_s),
        .depth_o (depth),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Sequencer FSM with registered outputs. phase_q mirrors the macro's
    // internal phase: 0 in the first cycle after reset, toggling each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            op_q        <= 2'b00;
            data_q      <= {DW{1'b0}};
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            din_q       <= {DW{1'b0}};
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            phase_q     <= ~phase_q;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        if (refuse_s) begin
                            state_q <= ERR;
                        end else if (phase_q) begin
                            // Next cycle is phase 0: strobe straight away.
                            state_q <= EXEC0;
                            push_q  <= is_push_s;
                            pop_q   <= is_pop_s;
                            din_q   <= cmd_data;
                        end else begin
                            state_q <= ALIGN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ALIGN: begin
                    state_q <= EXEC0;
                    push_q  <= (op_q == OP_PUSH);
                    pop_q   <= (op_q == OP_POP);
                    din_q   <= data_q;
                end
                EXEC0: begin
                    state_q <= EXEC1;
                end
                EXEC1: begin
                    state_q <= CAPT;
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                end
                CAPT: begin
                    // The macro registered mem[sp] at the end of EXEC1.
                    rsp_data_q  <= (op_q == OP_POP) ? stack_dout : data_q;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                ERR: begin
                    rsp_data_q  <= {DW{1'b0}};
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    push_q      <= 1'b0;
                    pop_q       <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign stack_push = push_q;
    assign stack_pop  = pop_q;
    assign stack_din  = din_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
module tb_stack_cmd_sequencer;

    localparam int TB_DEPTH = 4;
    localparam int TB_CW    = 9;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_data;
    logic             stack_push;
    logic             stack_pop;
    logic [7:0]       stack_din;
    logic [7:0]       stack_dout;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_err;
    logic [TB_CW-1:0] depth;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // Stack macro behavioural model and strobe monitor
    logic [7:0] mem [256];
    logic [7:0] sp;
    logic       m_ph;
    logic       prev_push, prev_pop;
    int         n_push = 0;
    int         n_pop = 0;
    int         bad_pair = 0;

    // LIFO reference contents
    logic [7:0] model[$];

    stack_cmd_sequencer #(.DEPTH(TB_DEPTH), .CW(TB_CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .stack_push(stack_push),
        .stack_pop(stack_pop), .stack_din(stack_din), .stack_dout(stack_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .depth(depth), .full(full), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ph       <= 1'b0;
            sp         <= 8'd0;
            stack_dout <= 8'd0;
            prev_push  <= 1'b0;
            prev_pop   <= 1'b0;
        end else begin
            m_ph <= ~m_ph;
            if (!m_ph) begin
                if (stack_push) mem[sp] <= stack_din;
                else if (stack_pop) sp <= sp - 8'd1;
            end else begin
                if (stack_push) sp <= sp + 8'd1;
                else if (stack_pop) stack_dout <= mem[sp];
                if (stack_push != prev_push || stack_pop != prev_pop) bad_pair <= bad_pair + 1;
            end
            if (stack_push && stack_pop) bad_pair <= bad_pair + 1;
            if (stack_push) n_push <= n_push + 1;
            if (stack_pop) n_pop <= n_pop + 1;
            prev_push <= stack_push;
            prev_pop  <= stack_pop;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called at #1 after an edge with the DUT idle)
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input bit hold);
        bit         exp_err;
        logic [7:0] exp_data;
        int         exp_lat;
        int         cyc;
        int         p0, q0;
        bit         seen;
        bit         ready_low;
        exp_err  = 1'b1;
        exp_data = 8'h00;
        if (op == 2'b01 && model.size() < TB_DEPTH) begin
            exp_err = 1'b0; exp_data = d; model.push_back(d);
        end else if (op == 2'b10 && model.size() > 0) begin
            exp_err = 1'b0; exp_data = model.pop_back();
        end
        exp_lat = exp_err ? 2 : (m_ph ? 4 : 5);
        check("ready_before", cmd_ready, 1);
        p0 = n_push; q0 = n_pop;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        cmd_op   = 2'($urandom);
        cmd_data = 8'($urandom);
        cyc = 1; seen = 1'b0; ready_low = 1'b1;
        while (!seen && cyc <= 20) begin
            if (cmd_ready !== 1'b0) ready_low = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("rsp_timeout", seen, 1);
        check("latency", cyc, exp_lat);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_data", rsp_data, exp_data);
        check("depth", depth, model.size());
        check("full", full, model.size() == TB_DEPTH);
        check("empty", empty, model.size() == 0);
        check("push_strobes", n_push - p0, (op == 2'b01 && !exp_err) ? 2 : 0);
        check("pop_strobes", n_pop - q0, (op == 2'b10 && !exp_err) ? 2 : 0);
        check("ready_low_busy", ready_low, 1);
        @(posedge clk); #1;
        check("ready_after", cmd_ready, 1);
        check("rsp_pulse_width", rsp_valid, 0);
        check("rsp_data_held", rsp_data, exp_data);
        check("rsp_err_held", rsp_err, exp_err);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int  wait_cnt;
        bit  no_rsp;
        int  r;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        model.delete();

        // Reset state
        check("rst_ready", cmd_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_depth", depth, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_strobes", {stack_push, stack_pop}, 0);
        check("rst_din", stack_din, 0);

        // Push 0xA5 in phase 0 (ALIGN path, latency 5)
        run_cmd(2'b01, 8'hA5, 1'b0);
        run_cmd(2'b10, 8'h00, 1'b0);
        // LIFO ordering
        run_cmd(2'b01, 8'h11, 1'b0);
        run_cmd(2'b01, 8'h22, 1'b0);
        run_cmd(2'b01, 8'h33, 1'b0);
        run_cmd(2'b10, 8'h00, 1'b0);
        run_cmd(2'b10, 8'h00, 1'b0);
        run_cmd(2'b10, 8'h00, 1'b0);
        // Pop from empty
        run_cmd(2'b10, 8'h5A, 1'b0);
        // Overflow at DEPTH = 4
        for (int i = 0; i < 5; i++) run_cmd(2'b01, 8'(8'hC0 + i), 1'b0);
        check("full_after_overflow", full, 1);
        run_cmd(2'b10, 8'h00, 1'b0);
        // Illegal opcodes and held valid
        run_cmd(2'b11, 8'h77, 1'b0);
        run_cmd(2'b00, 8'h66, 1'b0);
        run_cmd(2'b01, 8'h9C, 1'b1);
        @(posedge clk); #1;
        run_cmd(2'b10, 8'h00, 1'b1);

        // Reset during EXEC0 of a push
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'hEE;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_cnt = 0;
        while (stack_push !== 1'b1 && wait_cnt < 6) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("exec0_reached", stack_push, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_push", stack_push, 0);
        check("mid_rst_pop", stack_pop, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_depth", depth, 0);
        check("mid_rst_ready", cmd_ready, 1);
        rst = 1'b0;
        model.delete();
        no_rsp = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) no_rsp = 1'b0;
        end
        check("mid_rst_no_rsp", no_rsp, 1);

        // Randomized commands against the LIFO reference
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            r = $urandom_range(0, 9);
            if (r < 5)      run_cmd(2'b01, 8'($urandom), 1'($urandom));
            else if (r < 9) run_cmd(2'b10, 8'($urandom), 1'($urandom));
            else            run_cmd((r[0] ? 2'b11 : 2'b00), 8'($urandom), 1'b0);
        end

        check("strobe_pairing", bad_pair, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_cmd_sequencer.md
Name: stack_cmd_sequencer

Overview:
- Upstream command front-end for the 8-bit LIFO stack macro. Accepts push/pop commands over a valid/ready interface and converts each into the stack's two-cycle, phase-aligned push/pop strobe pattern.
- Tracks stack depth so that overflow and underflow are refused before they reach the macro.
- Captures popped bytes and returns one response per command.

Parameters:
- DEPTH, 256, number of stack entries; full when depth == DEPTH
- DW, 8, data width; fixed by the stack macro
- CW, 9, depth counter width; must satisfy 2**CW > DEPTH

Ports:
- clk  in  1  system clock; shared with the stack macro
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready
- cmd_op  in  2  01 = push, 10 = pop, 00/11 = illegal
- cmd_data  in  DW  byte to push
- stack_push  out  1  to stack push input
- stack_pop  out  1  to stack pop input
- stack_din  out  DW  to stack write data
- stack_dout  in  DW  stack output byte
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DW  popped byte (pop) or echoed byte (push)
- rsp_err  out  1  command refused; qualified by rsp_valid
- depth  out  CW  current entry count
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0

Behaviour:
- The stack macro alternates internal phase every cycle. In phase 0 it writes on push, or decrements the pointer on pop. In phase 1 it increments the pointer on push, or registers mem[sp] onto its output on pop.
- This block keeps a local phase bit: 0 in the first cycle after rst deasserts, toggling every cycle afterwards. System integration must release the stack's phase register on the same edge.
- Reset values: state IDLE, phase 0, depth 0, stack_push = stack_pop = 0, stack_din = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0. Consequently cmd_ready = 1, empty = 1, full = 0.
- States:
  - IDLE: cmd_ready = 1; all others 0. On accept, latch op and data.
    - Illegal op, push while full, or pop while empty → ERR.
    - Otherwise → EXEC0 if the next cycle is phase 0, else → ALIGN.
  - ALIGN: one wait cycle (phase 1) → EXEC0.
  - EXEC0: phase 0; drive stack_push or stack_pop = 1 and stack_din = latched data → EXEC1.
  - EXEC1: phase 1; same outputs as EXEC0. At exit, depth increments on push or decrements on pop → CAPT.
  - CAPT: strobes 0. rsp_data_q loads stack_dout on pop, or the latched data on push → DONE.
  - ERR: rsp_data_q = 0 and err flag set → DONE.
  - DONE: rsp_valid = 1, rsp_err = flag, rsp_data = rsp_data_q → IDLE.
- Strobes are high for exactly 2 consecutive cycles, always the pair phase 0 then phase 1. They are never asserted outside EXEC0/EXEC1.
- cmd_ready is low in every state except IDLE. There is no pipelining: one command is outstanding at a time. The response pulse is not back-pressured.
- Latency from accept edge to rsp_valid: 4 cycles when aligned, 5 when ALIGN is inserted. Error path: 2 cycles.
- depth saturates by construction: it never exceeds DEPTH and never goes below 0. At DEPTH = 256 the stack pointer wraps to 0, but depth reports 256 and full = 1.
- rsp_data, rsp_err are held between pulses; the consumer samples them only with rsp_valid.
- rst mid-command: next edge forces IDLE, strobes low, and no response is issued. The stack contents and pointer are not cleared by this block, so rst must accompany the stack-level reset.
- cmd_data, cmd_op changes after accept have no effect.

Decomposition:
- Shared package holds:
  - op encodings OP_PUSH = 2'b01, OP_POP = 2'b10
  - state enumeration IDLE/ALIGN/EXEC0/EXEC1/CAPT/ERR/DONE
  - DW constant
- One sub-module is natural: stack_depth_tracker (up/down counter plus full/empty flags, DEPTH parameter).
- Expected implementation size is around 200 lines.

Test Plan:
- Reset, then push 0xA5 accepted on cycle 0 (phase 0):
  - → ALIGN cycle 1, stack_push high on cycles 2 and 3.
  - → rsp_valid on cycle 5 with rsp_data = 0xA5, rsp_err = 0, depth = 1.
- Push 0x11, 0x22, 0x33, then pop ×3 → rsp_data sequence 0x33, 0x22, 0x11; depth returns to 0 and empty = 1.
- Pop from empty → no strobe ever asserted; rsp_valid 2 cycles after accept with rsp_err = 1, rsp_data = 0; depth stays 0.
- With DEPTH = 4, push 5 bytes → the fifth gets rsp_err = 1 and no stack_push; full = 1; a following pop returns the fourth byte.
- cmd_op = 2'b11 → rsp_err = 1 and no strobe. Separately, cmd_valid held during a push → cmd_ready = 0 until the cycle after rsp_valid.
- Assert rst during EXEC0 of a push → strobes low next cycle, no rsp_valid, depth = 0, cmd_ready = 1.
